// File: rtl/sorted_mem_sink_pkg.sv
// Shared widths, ordering defaults and FSM encoding for the sorted-memory sink.
package sorted_mem_sink_pkg;

    localparam int SM_DATA_WIDTH       = 8;
    localparam int SM_ELEMENT_NUM      = 8;
    localparam int SM_LOG2_ELEMENT_NUM = 3;
    localparam int SM_DESCENDING       = 1;
    localparam int SM_SIGNED_CMP       = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } sm_state_e;

endpackage

// File: rtl/sorted_mem_sink_sm_ram.sv
// Frame buffer: one write port, one registered read port; contents are not reset.
module sm_ram #(
    parameter int DATA_WIDTH  = 8,
    parameter int ELEMENT_NUM = 8,
    parameter int ADDR_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [ELEMENT_NUM];

    // storage write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/sorted_mem_sink.sv
// Captures one sorted frame from the SM stream, checks address/order, then drains it
// over valid/ready in index order.
import sorted_mem_sink_pkg::*;

module sorted_mem_sink #(
    parameter int DATA_WIDTH       = SM_DATA_WIDTH,
    parameter int ELEMENT_NUM      = SM_ELEMENT_NUM,
    parameter int LOG2_ELEMENT_NUM = SM_LOG2_ELEMENT_NUM,
    parameter int DESCENDING       = SM_DESCENDING,
    parameter int SIGNED_CMP       = SM_SIGNED_CMP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        sm_valid,
    input  logic [LOG2_ELEMENT_NUM-1:0] sm_addr,
    input  logic [DATA_WIDTH-1:0]       sm_data,
    input  logic                        sm_done,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        order_err,
    output logic                        addr_err,
    output logic                        early_done
);

    localparam int CW = LOG2_ELEMENT_NUM + 1;
    localparam logic [CW-1:0] N_C    = CW'(ELEMENT_NUM);
    localparam logic [CW-1:0] LAST_C = CW'(ELEMENT_NUM - 1);

    sm_state_e             state_r, state_s;
    logic [CW-1:0]         wr_cnt_r, rd_ptr_r;
    logic [DATA_WIDTH-1:0] prev_r;
    logic                  out_valid_r, out_last_r, busy_r, frame_done_r;
    logic                  order_err_r, addr_err_r, early_done_r;
    logic                  capturing_s, accept_s, hs_s, load_s;

    function automatic logic order_bad(input logic [DATA_WIDTH-1:0] cur,
                                       input logic [DATA_WIDTH-1:0] prev);
        logic gt, lt;
        if (SIGNED_CMP != 0) begin
            gt = $signed(cur) > $signed(prev);
            lt = $signed(cur) < $signed(prev);
        end else begin
            gt = cur > prev;
            lt = cur < prev;
        end
        return (DESCENDING != 0) ? gt : lt;
    endfunction

    assign capturing_s = (state_r == ST_IDLE) || (state_r == ST_CAPTURE);
    assign accept_s    = sm_valid && capturing_s;
    assign hs_s        = out_valid_r && out_ready;
    // Refill the output register whenever it is empty or being consumed this cycle.
    assign load_s      = (state_r == ST_DRAIN) && (!out_valid_r || out_ready) && (rd_ptr_r < N_C);

    // next-state logic; clr overrides every transition
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_CAPTURE: begin
                if (accept_s && (wr_cnt_r == LAST_C)) begin
                    state_s = ST_DRAIN;
                end else if (accept_s) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_DRAIN: begin
                if (hs_s && out_last_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_s = ST_DONE;
            default:  state_s = ST_IDLE;
        endcase
        if (clr) begin
            state_s = ST_IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // state, counters, sticky checks and registered drain outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            wr_cnt_r     <= '0;
            rd_ptr_r     <= '0;
            prev_r       <= '0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            order_err_r  <= 1'b0;
            addr_err_r   <= 1'b0;
            early_done_r <= 1'b0;
        end else if (clr) begin
            state_r      <= ST_IDLE;
            wr_cnt_r     <= '0;
            rd_ptr_r     <= '0;
            prev_r       <= '0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            order_err_r  <= 1'b0;
            addr_err_r   <= 1'b0;
            early_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s == ST_CAPTURE) || (state_s == ST_DRAIN);
            frame_done_r <= (state_s == ST_DONE);
            if (accept_s) begin
                wr_cnt_r <= wr_cnt_r + CW'(1);
                prev_r   <= sm_data;
                if ((wr_cnt_r != '0) && order_bad(sm_data, prev_r)) begin
                    order_err_r <= 1'b1;
                end
                if ({1'b0, sm_addr} != wr_cnt_r) begin
                    addr_err_r <= 1'b1;
                end
            end
            if (sm_done && capturing_s && (wr_cnt_r < N_C)) begin
                early_done_r <= 1'b1;
            end
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_last_r  <= (rd_ptr_r == LAST_C);
                rd_ptr_r    <= rd_ptr_r + CW'(1);
            end else if (hs_s) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
        end
    end

    sm_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ELEMENT_NUM (ELEMENT_NUM),
        .ADDR_WIDTH  (LOG2_ELEMENT_NUM)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (accept_s),
        .waddr (wr_cnt_r[LOG2_ELEMENT_NUM-1:0]),
        .wdata (sm_data),
        .re    (load_s),
        .raddr (rd_ptr_r[LOG2_ELEMENT_NUM-1:0]),
        .rdata (out_data)
    );

    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign order_err  = order_err_r;
    assign addr_err   = addr_err_r;
    assign early_done = early_done_r;

endmodule

// File: tb/tb_sorted_mem_sink.sv
// Directed bench for sorted_mem_sink: scoreboard queue filled at capture, emptied on handshakes.
module tb_sorted_mem_sink;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst, clr, sm_valid, sm_done, out_ready;
    logic [AW-1:0] sm_addr;
    logic [W-1:0]  sm_data;
    logic          out_valid, out_last, busy, frame_done, order_err, addr_err, early_done;
    logic [W-1:0]  out_data;

    int            checks = 0;
    int            errors = 0;
    int            drain_idx = 0;
    logic [W-1:0]  exp_q [$];
    logic          exp_order = 1'b0;
    logic          exp_addr  = 1'b0;

    logic [W-1:0]  d1 [N];
    logic [W-1:0]  d2 [N];
    logic [W-1:0]  d3 [N];
    logic [AW-1:0] a_ok [N];
    logic [AW-1:0] a_bad [N];

    sorted_mem_sink #(
        .DATA_WIDTH(W), .ELEMENT_NUM(N), .LOG2_ELEMENT_NUM(AW), .DESCENDING(1), .SIGNED_CMP(1)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .sm_valid(sm_valid), .sm_addr(sm_addr),
        .sm_data(sm_data), .sm_done(sm_done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .frame_done(frame_done),
        .order_err(order_err), .addr_err(addr_err), .early_done(early_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drives one frame (plus optional extra held-valid words) and tracks the flag model.
    task automatic send_frame(input logic [W-1:0] d [N], input logic [AW-1:0] a [N],
                              input int extra, input int done_at);
        for (int i = 0; i < N + extra; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("order_err", order_err, exp_order);
                chk("addr_err", addr_err, exp_addr);
                chk("busy_capture", busy, 1);
            end
            sm_valid = 1'b1;
            sm_done  = (i >= done_at);
            if (i < N) begin
                sm_data = d[i];
                sm_addr = a[i];
                exp_q.push_back(d[i]);
                if (i > 0 && ($signed(d[i]) > $signed(d[i-1]))) exp_order = 1'b1;
                if (a[i] != AW'(i)) exp_addr = 1'b1;
            end else begin
                sm_data = 8'hFF;
                sm_addr = 3'd0;
            end
        end
        @(negedge clk);
        chk("order_err_end", order_err, exp_order);
        chk("addr_err_end", addr_err, exp_addr);
        chk("busy_end", busy, 1);
        sm_valid = 1'b0;
        sm_done  = 1'b0;
    endtask

    // Consumes handshakes; toggle selects out_ready pattern 1,0,0,1 repeating.
    task automatic drain(input bit toggle, input int stop_after);
        int           hs = 0;
        int           k = 0;
        bit           held = 1'b0;
        logic [W-1:0] hd = '0;
        logic         hl = 1'b0;
        logic [W-1:0] e;
        while (hs < stop_after && k < 200) begin
            @(negedge clk);
            if (held) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, hd);
                chk("stall_last", out_last, hl);
            end
            out_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            k++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL extra_output: observed %0h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e);
                    chk("out_last", out_last, drain_idx == N - 1);
                end
                drain_idx++;
                hs++;
                held = 1'b0;
            end else begin
                held = out_valid;
                hd   = out_data;
                hl   = out_last;
            end
        end
        chk("drain_handshakes", hs, stop_after);
    endtask

    task automatic check_done();
        @(negedge clk);
        chk("frame_done", frame_done, 1);
        chk("busy_done", busy, 0);
        chk("valid_done", out_valid, 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr       = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        clr       = 1'b0;
        exp_order = 1'b0;
        exp_addr  = 1'b0;
        drain_idx = 0;
        exp_q.delete();
        chk("clr_busy", busy, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_frame_done", frame_done, 0);
        chk("clr_order_err", order_err, 0);
        chk("clr_addr_err", addr_err, 0);
        chk("clr_early_done", early_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        d1    = '{8'h7F, 8'h50, 8'h50, 8'h10, 8'h00, 8'hF0, 8'hC0, 8'h80};
        d2    = '{8'h7F, 8'h50, 8'h50, 8'h60, 8'h00, 8'hF0, 8'hC0, 8'h80};
        d3    = '{8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10, 8'h00};
        a_ok  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        a_bad = '{3'd0, 3'd1, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        rst = 1'b1; clr = 1'b0; sm_valid = 1'b0; sm_done = 1'b0; out_ready = 1'b0;
        sm_addr = '0; sm_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_flags", {order_err, addr_err, early_done, out_last}, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b0;

        // 1: signed descending frame, free-running drain
        send_frame(d1, a_ok, 0, 99);
        drain(1'b0, N);
        check_done();
        chk("t1_order_err", order_err, 0);
        do_clr();

        // 2: order violation at word 3, full drain still happens
        send_frame(d2, a_ok, 0, 99);
        drain(1'b0, N);
        check_done();
        chk("t2_order_err", order_err, 1);
        do_clr();

        // 3: bad address sequence, storage by arrival order
        send_frame(d1, a_bad, 0, 99);
        drain(1'b0, N);
        check_done();
        chk("t3_addr_err", addr_err, 1);
        chk("t3_order_err", order_err, 0);
        do_clr();

        // 4: stalling consumer
        send_frame(d3, a_ok, 0, 99);
        drain(1'b1, N);
        check_done();
        do_clr();

        // 5: sm_valid held 20 cycles, sm_done after the 8th word
        send_frame(d1, a_ok, 12, N);
        chk("t5_early_done", early_done, 0);
        drain(1'b0, N);
        check_done();
        do_clr();

        // 6: clr mid-drain, then a fresh frame
        send_frame(d3, a_ok, 0, 99);
        drain(1'b0, 3);
        do_clr();
        send_frame(d1, a_ok, 0, 99);
        drain(1'b0, N);
        check_done();
        do_clr();

        // 6b: premature sm_done, then asynchronous reset mid-capture
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sm_valid = 1'b1;
            sm_data  = d1[i];
            sm_addr  = AW'(i);
            sm_done  = (i == 2);
        end
        @(negedge clk);
        sm_valid = 1'b0;
        sm_done  = 1'b0;
        chk("early_done_set", early_done, 1);
        chk("busy_partial", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_early_done", early_done, 0);
        chk("arst_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(d3, a_ok, 0, 99);
        drain(1'b1, N);
        check_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
